// File: rtl/cdb_pkg.sv
// Shared types and default sizing for the common-data-bus arbiter slice.
// No logic; widths here size every CDB payload in the design.
package cdb_pkg;

    localparam int CDB_N_FU   = 4;
    localparam int CDB_N_CDB  = 2;
    localparam int CDB_DEPTH  = 2;
    localparam int CDB_PREG_W = 7;
    localparam int CDB_VAL_W  = 32;
    localparam int CDB_TAG_W  = 5;
    localparam int CDB_PC_W   = 32;

    typedef struct packed {
        logic [CDB_PREG_W-1:0] preg;
        logic [CDB_VAL_W-1:0]  val;
        logic [CDB_TAG_W-1:0]  tag;
        logic [CDB_PC_W-1:0]   pc;
        logic                  br_taken;
    } cdb_entry_t;

endpackage

// File: rtl/cdb_arbiter_multi_if.sv
// FU result ports, consumer controls and CDB broadcast lanes of the arbiter.
// master = FU/consumer side, slave = arbiter.
interface cdb_arbiter_multi_if
    import cdb_pkg::*;
#(
    parameter int N_FU   = CDB_N_FU,
    parameter int N_CDB  = CDB_N_CDB,
    parameter int PREG_W = CDB_PREG_W,
    parameter int VAL_W  = CDB_VAL_W,
    parameter int TAG_W  = CDB_TAG_W,
    parameter int PC_W   = CDB_PC_W
);
    localparam int SRC_W = (N_FU > 1) ? $clog2(N_FU) : 1;

    logic [N_FU-1:0]              fu_valid;
    logic [N_FU-1:0]              fu_ready;
    logic [N_FU-1:0][PREG_W-1:0]  fu_preg;
    logic [N_FU-1:0][VAL_W-1:0]   fu_val;
    logic [N_FU-1:0][TAG_W-1:0]   fu_tag;
    logic [N_FU-1:0][PC_W-1:0]    fu_pc;
    logic [N_FU-1:0]              fu_br_taken;
    logic                         cdb_stall;
    logic                         flush;
    logic [N_CDB-1:0]             cdb_valid;
    logic [N_CDB-1:0][PREG_W-1:0] cdb_preg;
    logic [N_CDB-1:0][VAL_W-1:0]  cdb_val;
    logic [N_CDB-1:0][TAG_W-1:0]  cdb_tag;
    logic [N_CDB-1:0][PC_W-1:0]   cdb_pc;
    logic [N_CDB-1:0]             cdb_br_taken;
    logic [N_CDB-1:0][SRC_W-1:0]  cdb_src;

    modport master (
        output fu_valid, fu_preg, fu_val, fu_tag, fu_pc, fu_br_taken, cdb_stall, flush,
        input  fu_ready, cdb_valid, cdb_preg, cdb_val, cdb_tag, cdb_pc, cdb_br_taken, cdb_src
    );

    modport slave (
        input  fu_valid, fu_preg, fu_val, fu_tag, fu_pc, fu_br_taken, cdb_stall, flush,
        output fu_ready, cdb_valid, cdb_preg, cdb_val, cdb_tag, cdb_pc, cdb_br_taken, cdb_src
    );

endinterface

// File: rtl/cdb_fu_fifo.sv
// Per-FU result FIFO, DEPTH entries; head visible combinationally, pop takes effect next edge.
// Caller gates push with count < DEPTH; flush/reset empty it and drop same-cycle pushes.
module cdb_fu_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic [W-1:0]               push_dat,
    input  logic                       pop,
    output logic [W-1:0]               head_dat,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push && !flush && !reset) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head_dat = mem[rd_ptr];

endmodule

// File: rtl/cdb_arbiter_multi.sv
// Round-robin multi-grant CDB arbiter: N_FU result FIFOs onto N_CDB registered lanes.
// Latency 2 cycles fu_valid->cdb_valid; FU stalls only on its own full FIFO, cdb_stall freezes grants.
module cdb_arbiter_multi
    import cdb_pkg::*;
#(
    parameter int N_FU   = CDB_N_FU,
    parameter int N_CDB  = CDB_N_CDB,
    parameter int DEPTH  = CDB_DEPTH,
    parameter int PREG_W = CDB_PREG_W,
    parameter int VAL_W  = CDB_VAL_W,
    parameter int TAG_W  = CDB_TAG_W,
    parameter int PC_W   = CDB_PC_W
) (
    input logic                 clk,
    input logic                 reset,
    cdb_arbiter_multi_if.slave  bus
);
    localparam int SRC_W = (N_FU > 1) ? $clog2(N_FU) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);

    cdb_entry_t             push_dat [N_FU];
    cdb_entry_t             head_dat [N_FU];
    logic [CNT_W-1:0]       count    [N_FU];
    logic [N_FU-1:0]        push;
    logic [N_FU-1:0]        nonempty;
    logic [N_FU-1:0]        grant;
    logic [N_CDB-1:0]       lane_vld;
    logic [SRC_W-1:0]       lane_sel [N_CDB];
    logic [SRC_W-1:0]       rr_ptr;
    logic [SRC_W-1:0]       rr_nxt;
    cdb_entry_t             lane_dat [N_CDB];
    logic [SRC_W-1:0]       lane_src [N_CDB];
    int                     idx;
    int                     n_g;

    for (genvar i = 0; i < N_FU; i++) begin : g_fu
        assign push_dat[i].preg     = bus.fu_preg[i];
        assign push_dat[i].val      = bus.fu_val[i];
        assign push_dat[i].tag      = bus.fu_tag[i];
        assign push_dat[i].pc       = bus.fu_pc[i];
        assign push_dat[i].br_taken = bus.fu_br_taken[i];
        // ready ignores same-cycle pops so it never depends on the grant path
        assign bus.fu_ready[i] = (count[i] < CNT_W'(DEPTH)) && !reset;
        assign push[i]         = bus.fu_valid[i] && bus.fu_ready[i];
        assign nonempty[i]     = (count[i] != '0);

        cdb_fu_fifo #(
            .DEPTH (DEPTH),
            .W     ($bits(cdb_entry_t))
        ) u_fifo (
            .clk      (clk),
            .reset    (reset),
            .flush    (bus.flush),
            .push     (push[i]),
            .push_dat (push_dat[i]),
            .pop      (grant[i]),
            .head_dat (head_dat[i]),
            .count    (count[i])
        );
    end

    always_comb begin
        grant    = '0;
        lane_vld = '0;
        rr_nxt   = rr_ptr;
        idx      = 0;
        n_g      = 0;
        for (int k = 0; k < N_CDB; k++) lane_sel[k] = '0;
        if (!reset && !bus.flush && !bus.cdb_stall) begin
            for (int k = 0; k < N_FU; k++) begin
                idx = (int'(rr_ptr) + k) % N_FU;
                if (nonempty[idx] && (n_g < N_CDB)) begin
                    grant[idx]    = 1'b1;
                    lane_vld[n_g] = 1'b1;
                    lane_sel[n_g] = SRC_W'(idx);
                    rr_nxt        = SRC_W'((idx + 1) % N_FU);
                    n_g           = n_g + 1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr        <= '0;
            bus.cdb_valid <= '0;
            for (int k = 0; k < N_CDB; k++) begin
                lane_dat[k] <= '0;
                lane_src[k] <= '0;
            end
        end else begin
            rr_ptr        <= rr_nxt;
            bus.cdb_valid <= lane_vld;
            for (int k = 0; k < N_CDB; k++) begin
                if (lane_vld[k]) begin
                    lane_dat[k] <= head_dat[lane_sel[k]];
                    lane_src[k] <= lane_sel[k];
                end
            end
        end
    end

    for (genvar k = 0; k < N_CDB; k++) begin : g_lane
        assign bus.cdb_preg[k]     = lane_dat[k].preg;
        assign bus.cdb_val[k]      = lane_dat[k].val;
        assign bus.cdb_tag[k]      = lane_dat[k].tag;
        assign bus.cdb_pc[k]       = lane_dat[k].pc;
        assign bus.cdb_br_taken[k] = lane_dat[k].br_taken;
        assign bus.cdb_src[k]      = lane_src[k];
    end

endmodule

// File: tb/tb_cdb_arbiter_multi.sv
// Scoreboard bench: queue-based reference model predicts every lane result; negedge monitor checks.
module tb_cdb_arbiter_multi;
    import cdb_pkg::*;

    localparam int N_FU  = 4;
    localparam int N_CDB = 2;
    localparam int DEPTH = 2;

    typedef struct {
        int         cyc;
        int         lane;
        int         src;
        cdb_entry_t e;
    } rec_t;

    logic clk;
    logic reset;
    int   cyc;
    int   total;
    int   bad;

    rec_t       exp_q [$];
    cdb_entry_t mq [N_FU][$];
    bit         rst_at [int];
    int         rr;
    cdb_entry_t d [N_FU];

    cdb_arbiter_multi_if #(.N_FU(N_FU), .N_CDB(N_CDB)) bus ();

    cdb_arbiter_multi #(.N_FU(N_FU), .N_CDB(N_CDB), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, req);
        end
    endtask

    task automatic rnd_pay();
        for (int i = 0; i < N_FU; i++) begin
            d[i].preg     = CDB_PREG_W'($urandom);
            d[i].val      = $urandom;
            d[i].tag      = CDB_TAG_W'($urandom);
            d[i].pc       = $urandom;
            d[i].br_taken = 1'($urandom);
        end
    endtask

    // Drive one cycle of inputs and advance the reference model across the coming edge.
    task automatic step(input bit r, input bit f, input bit s, input logic [N_FU-1:0] v);
        logic [N_FU-1:0] rdy;
        int g;
        int last;
        int n;
        int i;
        rec_t rc;
        @(posedge clk);
        #1;
        reset         = r;
        bus.flush     = f;
        bus.cdb_stall = s;
        bus.fu_valid  = v;
        for (int k = 0; k < N_FU; k++) begin
            bus.fu_preg[k]     = d[k].preg;
            bus.fu_val[k]      = d[k].val;
            bus.fu_tag[k]      = d[k].tag;
            bus.fu_pc[k]       = d[k].pc;
            bus.fu_br_taken[k] = d[k].br_taken;
        end
        #1;
        n = cyc;
        for (int k = 0; k < N_FU; k++) rdy[k] = (mq[k].size() < DEPTH) && !r;
        chk("fu_ready", 128'(bus.fu_ready), 128'(rdy));
        if (r) begin
            for (int k = 0; k < N_FU; k++) mq[k].delete();
            rr = 0;
            rst_at[n+1] = 1'b1;
        end else if (f) begin
            for (int k = 0; k < N_FU; k++) mq[k].delete();
        end else begin
            if (!s) begin
                g = 0;
                last = -1;
                for (int k = 0; k < N_FU; k++) begin
                    i = (rr + k) % N_FU;
                    if (mq[i].size() > 0 && g < N_CDB) begin
                        rc.cyc  = n + 1;
                        rc.lane = g;
                        rc.src  = i;
                        rc.e    = mq[i].pop_front();
                        exp_q.push_back(rc);
                        g++;
                        last = i;
                    end
                end
                if (g > 0) rr = (last + 1) % N_FU;
            end
            for (int k = 0; k < N_FU; k++)
                if (v[k] && rdy[k]) mq[k].push_back(d[k]);
        end
    endtask

    always @(negedge clk) begin
        logic [N_CDB-1:0] em;
        cdb_entry_t       ee [N_CDB];
        int               es [N_CDB];
        cdb_entry_t       ae;
        rec_t             r;
        if (cyc >= 2) begin
            em = '0;
            for (int k = 0; k < N_CDB; k++) begin
                ee[k] = '0;
                es[k] = 0;
            end
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                r = exp_q.pop_front();
                em[r.lane] = 1'b1;
                ee[r.lane] = r.e;
                es[r.lane] = r.src;
            end
            chk("cdb_valid", 128'(bus.cdb_valid), 128'(em));
            for (int k = 0; k < N_CDB; k++) begin
                if (em[k] && bus.cdb_valid[k]) begin
                    ae.preg     = bus.cdb_preg[k];
                    ae.val      = bus.cdb_val[k];
                    ae.tag      = bus.cdb_tag[k];
                    ae.pc       = bus.cdb_pc[k];
                    ae.br_taken = bus.cdb_br_taken[k];
                    chk("lane_payload", 128'(ae), 128'(ee[k]));
                    chk("lane_src", 128'(bus.cdb_src[k]), 128'(es[k]));
                end
            end
            if (rst_at.exists(cyc)) begin
                chk("reset_small", 128'({bus.cdb_preg, bus.cdb_tag, bus.cdb_br_taken, bus.cdb_src}), 128'(0));
                chk("reset_val_pc", {bus.cdb_val, bus.cdb_pc}, 128'(0));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        total = 0;
        bad   = 0;
        rr    = 0;
        reset = 1'b1;
        bus.flush     = 1'b0;
        bus.cdb_stall = 1'b0;
        bus.fu_valid  = '0;
        rnd_pay();
        for (int k = 0; k < N_FU; k++) begin
            bus.fu_preg[k]     = '0;
            bus.fu_val[k]      = '0;
            bus.fu_tag[k]      = '0;
            bus.fu_pc[k]       = '0;
            bus.fu_br_taken[k] = 1'b0;
        end

        repeat (3) step(1, 0, 0, '0);
        repeat (2) step(0, 0, 0, '0);

        // single result from FU2
        d[2].preg = 7'd5; d[2].val = 32'hDEADBEEF; d[2].tag = 5'd3; d[2].pc = 32'h100; d[2].br_taken = 1'b0;
        step(0, 0, 0, 4'b0100);
        repeat (3) step(0, 0, 0, '0);

        // all four contend in one cycle
        rnd_pay();
        step(0, 0, 0, 4'b1111);
        repeat (3) step(0, 0, 0, '0);

        // FU0 and FU3 back-to-back
        for (int j = 0; j < 8; j++) begin
            rnd_pay();
            step(0, 0, 0, 4'b1001);
        end
        repeat (3) step(0, 0, 0, '0);

        // consumer stall while FU1 keeps offering
        for (int j = 0; j < 4; j++) begin
            rnd_pay();
            step(0, 0, 1, 4'b0010);
        end
        repeat (4) step(0, 0, 0, '0);

        // flush while results are buffered and a grant is due
        rnd_pay(); step(0, 0, 1, 4'b0111);
        rnd_pay(); step(0, 0, 1, 4'b0111);
        step(0, 1, 0, '0);
        repeat (3) step(0, 0, 0, '0);

        // reset with two full FIFOs
        rnd_pay(); step(0, 0, 1, 4'b0011);
        rnd_pay(); step(0, 0, 1, 4'b0011);
        rnd_pay(); step(1, 0, 0, 4'b1111);
        repeat (4) step(0, 0, 0, '0);

        for (int j = 0; j < 1500; j++) begin
            rnd_pay();
            step(($urandom % 200) == 0, ($urandom % 50) == 0, ($urandom % 6) == 0, 4'($urandom));
        end

        repeat (10) step(0, 0, 0, '0);
        @(negedge clk);
        #1;
        chk("drained", 128'(exp_q.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
